swing_arbiter: RTL and testbench

//  Shares one sultans_of_swing datapath (registered Ao=Ai, Bo=Bi, ANDo=(Ai^Bi)&Ci; 1-cycle latency)

---
 rtl/swing_arb_pkg.sv | 51 +++++
 rtl/sultans_of_swing.sv | 34 +++
 rtl/swing_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_swing_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swing_arb_pkg.sv
// swing_arb_pkg
//   Shared definitions for the swing arbiter: FSM state encoding, the operand
//   width fixed by the sultans_of_swing datapath, pointer sizing for up to
//   eight requesters, and the round-robin pick function.
package swing_arb_pkg;

  localparam int DATA_W  = 4;  // operand width of the swing datapath
  localparam int MAX_REQ = 8;  // largest supported requester count
  localparam int PTR_W   = 3;  // wide enough to index MAX_REQ requesters

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Returns the first index at or after ptr (modulo num_req) whose valid bit
  // is set. The result is meaningless when no valid bit is set; callers gate
  // it with a reduction-OR of valid.
  function automatic logic [PTR_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [PTR_W-1:0]   ptr,
    input int unsigned        num_req
  );
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] idx;
    logic [PTR_W:0]   sum;
    logic             found;
    pick  = '0;
    idx   = '0;
    sum   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < num_req) begin
        // ptr < num_req and k < num_req, so one conditional subtract
        // is enough to wrap the sum back into range.
        sum = {1'b0, ptr} + (PTR_W+1)'(k);
        if (32'(sum) >= num_req) begin
          sum = sum - (PTR_W+1)'(num_req);
        end
        idx = sum[PTR_W-1:0];
        if (!found && valid[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sultans_of_swing.sv
// sultans_of_swing
//   Registered swing datapath with one cycle of latency:
//     Ao = Ai, Bo = Bi, ANDo = (Ai ^ Bi) & Ci
// Ports
//   clk            clock, all logic on posedge
//   reset          synchronous active-high reset, clears all outputs
//   Ai, Bi, Ci     operands
//   Ao, Bo, ANDo   registered results
module sultans_of_swing
  import swing_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Ai,
  input  logic [DATA_W-1:0] Bi,
  input  logic [DATA_W-1:0] Ci,
  output logic [DATA_W-1:0] Ao,
  output logic [DATA_W-1:0] Bo,
  output logic [DATA_W-1:0] ANDo
);

  always_ff @(posedge clk) begin
    if (reset) begin
      Ao   <= '0;
      Bo   <= '0;
      ANDo <= '0;
    end else begin
      Ao   <= Ai;
      Bo   <= Bi;
      ANDo <= (Ai ^ Bi) & Ci;
    end
  end

endmodule

// File: rtl/swing_arbiter.sv
// swing_arbiter
//   Shares one sultans_of_swing datapath between NUM_REQ requesters using
//   round-robin arbitration. Each accepted operand triple produces one
//   response tagged with the owning requester index.
// Ports
//   clk        clock, all logic on posedge
//   reset      synchronous active-high reset (also resets the datapath)
//   req_valid  per-requester operand pending
//   req_ready  per-requester accept, one-hot or zero
//   req_a/b/c  packed operands, slice i = [i*DATA_W +: DATA_W]
//   rsp_valid  response available
//   rsp_ready  consumer accepts the response
//   rsp_id     requester index owning the response
//   rsp_a/b/and datapath outputs
//   busy       high while a request is in EXEC or RESP
module swing_arbiter
  import swing_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*DATA_W-1:0] req_c,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_a,
  output logic [DATA_W-1:0]         rsp_b,
  output logic [DATA_W-1:0]         rsp_and,
  output logic                      busy
);

  // Configuration guards: the datapath width is fixed, and the id must be
  // able to name every requester.
  generate
    if (DATA_W != swing_arb_pkg::DATA_W) begin : g_bad_data_w
      $error("swing_arbiter: DATA_W must equal the datapath width");
    end
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("swing_arbiter: NUM_REQ must be in 2..8");
    end
    if (ID_W < $clog2(NUM_REQ)) begin : g_bad_id_w
      $error("swing_arbiter: ID_W too narrow for NUM_REQ");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  c_q, c_d;

  logic [MAX_REQ-1:0] valid_ext;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   grant_next_ptr;
  logic [NUM_REQ-1:0] grant_oh;
  logic [DATA_W-1:0]  a_masked [NUM_REQ];
  logic [DATA_W-1:0]  b_masked [NUM_REQ];
  logic [DATA_W-1:0]  c_masked [NUM_REQ];
  logic [DATA_W-1:0]  a_sel, b_sel, c_sel;
  logic               any_valid;
  logic               do_grant;

  // ---------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid;
  end

  assign any_valid      = |req_valid;
  assign grant_idx      = rr_pick(valid_ext, rr_ptr_q, NUM_REQ);
  assign grant_next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                             : grant_idx + 1'b1;

  // One-hot grant and AND-masked operand slices; OR-reducing the masked
  // slices gives the granted requester's operands without a wide index.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign grant_oh[gi] = (grant_idx == PTR_W'(gi));
      assign a_masked[gi] = req_a[gi*DATA_W +: DATA_W] & {DATA_W{grant_oh[gi]}};
      assign b_masked[gi] = req_b[gi*DATA_W +: DATA_W] & {DATA_W{grant_oh[gi]}};
      assign c_masked[gi] = req_c[gi*DATA_W +: DATA_W] & {DATA_W{grant_oh[gi]}};
    end
  endgenerate

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    c_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_sel = a_sel | a_masked[i];
      b_sel = b_sel | b_masked[i];
      c_sel = c_sel | c_masked[i];
    end
  end

  // ---------------------------------------------------------------------
  // Arbiter FSM: next state and request-side outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    req_ready = '0;
    do_grant  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          do_grant = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        // Completing the response and accepting the next request in the
        // same cycle is what gives one response every two cycles.
        if (rsp_ready) begin
          if (any_valid) begin
            do_grant = 1'b1;
            state_d  = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_grant) begin
      req_ready = grant_oh;
      a_d       = a_sel;
      b_d       = b_sel;
      c_d       = c_sel;
      id_d      = ID_W'(grant_idx);
      rr_ptr_d  = grant_next_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
    end
  end

  // ---------------------------------------------------------------------
  // Shared datapath. The operand registers only change on a grant, so
  // while in RESP the datapath keeps re-registering the same result.
  // ---------------------------------------------------------------------
  sultans_of_swing u_datapath (
    .clk   (clk),
    .reset (reset),
    .Ai    (a_q),
    .Bi    (b_q),
    .Ci    (c_q),
    .Ao    (rsp_a),
    .Bo    (rsp_b),
    .ANDo  (rsp_and)
  );

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_swing_arbiter.sv
module tb_swing_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a, req_b, req_c;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_a, rsp_b, rsp_and;
  logic            busy;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] andv;
  } rsp_t;

  rsp_t          exp_q[$];
  int            exp_order[$];
  logic [DW-1:0] op_a [N];
  logic [DW-1:0] op_b [N];
  logic [DW-1:0] op_c [N];
  int            checks = 0;
  int            errors = 0;
  rsp_t          mon_exp, mon_got;

  swing_arbiter #(.NUM_REQ(N), .ID_W(2), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b),
    .rsp_and   (rsp_and),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference result for requester i, from the datapath definition.
  function automatic rsp_t model(input int i);
    rsp_t r;
    r.id   = 2'(i);
    r.a    = op_a[i];
    r.b    = op_b[i];
    r.andv = (op_a[i] ^ op_b[i]) & op_c[i];
    return r;
  endfunction

  // Scoreboard monitor: handshake rules every cycle, response compare on
  // every accepted response.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (($countones(req_ready) > 1) || ((req_ready & ~req_valid) != '0)) begin
        errors++;
        $display("FAIL handshake: req_ready=%b req_valid=%b, required one-hot/zero subset of valid",
                 req_ready, req_valid);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        mon_got = {rsp_id, rsp_a, rsp_b, rsp_and};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got id=%0d a=%b b=%b and=%b, required no response",
                   rsp_id, rsp_a, rsp_b, rsp_and);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL rsp_data: got id=%0d a=%b b=%b and=%b, required id=%0d a=%b b=%b and=%b",
                     mon_got.id, mon_got.a, mon_got.b, mon_got.andv,
                     mon_exp.id, mon_exp.a, mon_exp.b, mon_exp.andv);
          end else begin
            $display("[%0t] rsp id=%0d a=%b b=%b and=%b", $time,
                     rsp_id, rsp_a, rsp_b, rsp_and);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Holds 'mask' valid, checks each grant against exp_order and the
  // two-cycle grant spacing, and pushes the expected response per grant.
  task automatic run_seq(input logic [N-1:0] mask, input bit drop);
    int           n     = exp_order.size();
    int           got_n = 0;
    int           cyc   = 0;
    int           last  = -1;
    logic [N-1:0] cur   = mask;
    logic [N-1:0] exp_oh;
    req_valid = cur;
    while (got_n < n && cyc < 40) begin
      @(negedge clk);
      if (req_ready != '0) begin
        exp_oh = 4'b0001 << exp_order[got_n];
        checks++;
        if (req_ready !== exp_oh) begin
          errors++;
          $display("FAIL grant_order: grant #%0d req_ready=%b, required %b", got_n, req_ready, exp_oh);
        end
        exp_q.push_back(model(exp_order[got_n]));
        if (last >= 0) begin
          checks++;
          if (cyc - last != 2) begin
            errors++;
            $display("FAIL grant_spacing: %0d cycles between grants, required 2", cyc - last);
          end
        end
        last = cyc;
        got_n++;
        if (drop) cur = cur & ~exp_oh;
      end
      tick();
      cyc++;
      req_valid = (got_n < n) ? cur : '0;
    end
    req_valid = '0;
    checks++;
    if (got_n < n) begin
      errors++;
      $display("FAIL grant_timeout: %0d grants seen, required %0d", got_n, n);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_a, rsp_b, rsp_and, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b id=%0d a=%b b=%b and=%b busy=%b, required all 0",
               req_ready, rsp_valid, rsp_id, rsp_a, rsp_b, rsp_and, busy);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_and !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b rsp_valid=%b and=%b, required 0 0 0000",
               busy, rsp_valid, rsp_and);
    end
    tick();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: req_ready=%b, required 0001", req_ready);
    end
    exp_q.push_back(model(0));
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL single_exec: rsp_valid=%b busy=%b req_ready=%b, required 0 1 0000",
               rsp_valid, busy, req_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: rsp_valid=%b two cycles after accept, required 1", rsp_valid);
    end
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    rsp_ready = 1'b1;
    exp_order = '{0, 1, 2, 3, 0};
    run_seq(4'b1111, 1'b0);
    drain();
  endtask

  task automatic test_skip();
    do_reset();
    rsp_ready = 1'b1;
    exp_order = '{2};
    run_seq(4'b0100, 1'b1);
    drain();
    exp_order = '{3, 1};
    run_seq(4'b1010, 1'b1);
    drain();
  endtask

  // Pointer is 2 here, so req0 wins by wrap-around. During the hold req2
  // and req3 are valid; req2 withdraws before acceptance and is skipped.
  task automatic test_backpressure();
    rsp_t hold_exp;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_wrap_grant: req_ready=%b, required 0001", req_ready);
    end
    hold_exp = model(0);
    exp_q.push_back(hold_exp);
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b1100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== '0 ||
          {rsp_id, rsp_a, rsp_b, rsp_and} !== hold_exp) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b id=%0d a=%b b=%b and=%b, required 1 0000 id=0 a=%b b=%b and=%b",
                 k, rsp_valid, req_ready, rsp_id, rsp_a, rsp_b, rsp_and,
                 hold_exp.a, hold_exp.b, hold_exp.andv);
      end
      tick();
      if (k == 3) req_valid = 4'b1000;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_grant: req_ready=%b, required 1000", req_ready);
    end
    exp_q.push_back(model(3));
    tick();
    req_valid = '0;
    drain();
  endtask

  // Pointer is 0 here. req2 is accepted, then reset lands during EXEC; its
  // result must never show up and the pointer must be back at 0.
  task automatic test_reset_exec();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rst_exec_grant: req_ready=%b, required 0100", req_ready);
    end
    tick();
    req_valid = '0;
    reset     = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_exec_state: busy=%b, required 1", busy);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== '0 ||
        rsp_a !== '0 || rsp_b !== '0 || rsp_and !== '0) begin
      errors++;
      $display("FAIL rst_exec_clear: valid=%b busy=%b id=%0d a=%b b=%b and=%b, required all 0",
               rsp_valid, busy, rsp_id, rsp_a, rsp_b, rsp_and);
    end
    tick();
    req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rst_exec_ptr: req_ready=%b, required 0010 (pointer back at 0)", req_ready);
    end
    exp_q.push_back(model(1));
    tick();
    req_valid = '0;
    drain();
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_exec_idle: busy=%b, required 0", busy);
    end
  endtask

  initial begin
    op_a[0] = 4'b0011; op_b[0] = 4'b0110; op_c[0] = 4'b0001;
    op_a[1] = 4'b1110; op_b[1] = 4'b0011; op_c[1] = 4'b1011;
    op_a[2] = 4'b0101; op_b[2] = 4'b1010; op_c[2] = 4'b1111;
    op_a[3] = 4'b1000; op_b[3] = 4'b0001; op_c[3] = 4'b0111;
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = op_a[i];
      req_b[i*DW +: DW] = op_b[i];
      req_c[i*DW +: DW] = op_c[i];
    end
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_backpressure();
    test_reset_exec();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
